// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle shift-by-N sequencer driving a single-bit shift step
//
// Purpose: performs LSL/LSR/ASR/ROL by 0..2**AMT_W-1 bit positions on a
// WIDTH-bit operand, one bit step per clock, in place of a barrel shifter.
//
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous active-high reset
//   start   - operation request, sampled only while idle
//   operand - value to shift, captured on an accepted start
//   amount  - number of single-bit steps, captured on an accepted start
//   mode    - 00=LSL 01=LSR 10=ASR 11=ROL, captured on an accepted start
//   busy    - high while an operation is in flight
//   done    - one-cycle pulse; result/carry/zero valid from this cycle
//   result  - shifted value, held until the next done
//   carry   - last bit shifted/rotated out (0 for amount=0)
//   zero    - result==0, updated together with result
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] operand,
    input  logic [AMT_W-1:0] amount,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    logic [0:0]       state_q,  state_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [AMT_W-1:0] cnt_q,    cnt_d;
    logic             cbit_q,   cbit_d;
    logic [1:0]       mode_q,   mode_d;
    logic             done_q,   done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q,  carry_d;
    logic             zero_q,   zero_d;

    // One bit step of the latched mode applied to the accumulator.
    logic [WIDTH-1:0] step_acc;
    logic             step_out;

    always_comb begin
        step_acc = acc_q;
        step_out = 1'b0;
        case (mode_q)
            MODE_LSL: begin
                step_acc = {acc_q[WIDTH-2:0], 1'b0};
                step_out = acc_q[WIDTH-1];
            end
            MODE_LSR: begin
                step_acc = {1'b0, acc_q[WIDTH-1:1]};
                step_out = acc_q[0];
            end
            MODE_ASR: begin
                step_acc = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
                step_out = acc_q[0];
            end
            MODE_ROL: begin
                step_acc = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]};
                step_out = acc_q[WIDTH-1];
            end
            default: begin
                step_acc = acc_q;
                step_out = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        cbit_d   = cbit_q;
        mode_d   = mode_q;
        done_d   = 1'b0;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;

        case (state_q)
            ST_IDLE: begin
                // The done cycle is spent in IDLE, so a start seen alongside
                // done is accepted here and operations can run back-to-back.
                if (start) begin
                    acc_d   = operand;
                    cnt_d   = amount;
                    cbit_d  = 1'b0;
                    mode_d  = mode;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    acc_d  = step_acc;
                    cbit_d = step_out;
                    cnt_d  = cnt_q - AMT_W'(1);
                end else begin
                    // Final cycle publishes the accumulator; outputs hold
                    // from here until the next completion.
                    result_d = acc_q;
                    carry_d  = cbit_q;
                    zero_d   = (acc_q == '0);
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            cbit_q   <= 1'b0;
            mode_q   <= MODE_LSL;
            done_q   <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            cbit_q   <= cbit_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    assign busy   = (state_q == ST_SHIFT);
    assign done   = done_q;
    assign result = result_q;
    assign carry  = carry_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - self-checking bench for shift_sequencer
module tb_shift_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] operand;
    logic [3:0] amount;
    logic [1:0] mode;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       carry;
    logic       zero;

    int tests = 0;
    int fails = 0;
    logic [7:0] last_result;

    shift_sequencer #(.WIDTH(8), .AMT_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .operand (operand),
        .amount  (amount),
        .mode    (mode),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .carry   (carry),
        .zero    (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] operand;
        logic [3:0] amount;
        logic [7:0] exp_result;
        logic       exp_carry;
        logic       exp_zero;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: whole-operation arithmetic on wide words; returns {carry, result}.
    function automatic logic [8:0] ref_shift(input logic [1:0] m, input logic [7:0] op, input int n);
        logic [23:0] w;
        logic [15:0] w16;
        logic [7:0]  r;
        logic        c;
        r = 8'h00;
        c = 1'b0;
        case (m)
            2'd0: begin w = {16'h0000, op} << n; r = w[7:0];   c = w[8];  end
            2'd1: begin w = {op, 16'h0000} >> n; r = w[23:16]; c = w[15]; end
            2'd2: begin
                w = $signed({op, 16'h0000}) >>> n;
                r = w[23:16];
                c = w[15];
            end
            default: begin
                w16 = {op, op} << (n % 8);
                r = w16[15:8];
                c = r[0];
            end
        endcase
        if (n == 0) c = 1'b0;
        return {c, r};
    endfunction

    task automatic issue(input logic [1:0] m, input logic [7:0] op, input logic [3:0] n);
        mode    = m;
        operand = op;
        amount  = n;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts cycles from acceptance until done; optionally disturbs inputs meanwhile.
    task automatic wait_done(input bit scramble, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (scramble) begin
                operand = 8'($urandom);
                amount  = 4'($urandom);
                mode    = 2'($urandom);
            end
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] m, input logic [7:0] op,
                          input logic [3:0] n, input logic [7:0] er, input logic ec,
                          input logic ez, input bit b2b, input bit scramble);
        int cyc;
        bit ok;
        if (!b2b) @(negedge clk);
        issue(m, op, n);
        check({name, " busy"}, {31'b0, busy}, 32'd1);
        check({name, " hold"}, {24'b0, result}, {24'b0, last_result});
        wait_done(scramble, cyc, ok);
        check({name, " done seen"}, {31'b0, ok}, 32'd1);
        check({name, " latency"}, cyc, n + 1);
        check({name, " result"}, {24'b0, result}, {24'b0, er});
        check({name, " carry"}, {31'b0, carry}, {31'b0, ec});
        check({name, " zero"}, {31'b0, zero}, {31'b0, ez});
        check({name, " idle"}, {31'b0, busy}, 32'd0);
        last_result = er;
    endtask

    initial begin
        logic [8:0] rv;
        int         first_done;
        int         ndone;

        vecs[0]  = '{2'd0, 8'b11001010, 4'd1,  8'b10010100, 1'b1, 1'b0};
        vecs[1]  = '{2'd0, 8'b00001111, 4'd3,  8'b01111000, 1'b0, 1'b0};
        vecs[2]  = '{2'd0, 8'b10000000, 4'd1,  8'h00,       1'b1, 1'b1};
        vecs[3]  = '{2'd1, 8'b11001010, 4'd2,  8'b00110010, 1'b1, 1'b0};
        vecs[4]  = '{2'd2, 8'b10000000, 4'd3,  8'b11110000, 1'b0, 1'b0};
        vecs[5]  = '{2'd3, 8'b11001010, 4'd4,  8'b10101100, 1'b0, 1'b0};
        vecs[6]  = '{2'd0, 8'h5A,       4'd0,  8'h5A,       1'b0, 1'b0};
        vecs[7]  = '{2'd0, 8'hFF,       4'd8,  8'h00,       1'b1, 1'b1};
        vecs[8]  = '{2'd1, 8'h80,       4'd8,  8'h00,       1'b1, 1'b1};
        vecs[9]  = '{2'd3, 8'hCA,       4'd15, 8'h65,       1'b1, 1'b0};
        vecs[10] = '{2'd2, 8'h80,       4'd15, 8'hFF,       1'b1, 1'b0};

        rst = 1'b1;
        start = 1'b0;
        operand = 8'h00;
        amount = 4'd0;
        mode = 2'd0;
        last_result = 8'h00;
        #1;
        check("reset busy",   {31'b0, busy},   32'd0);
        check("reset done",   {31'b0, done},   32'd0);
        check("reset result", {24'b0, result}, 32'd0);
        check("reset carry",  {31'b0, carry},  32'd0);
        check("reset zero",   {31'b0, zero},   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed table; odd entries start in the done cycle of the previous one.
        for (int i = 0; i < 11; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].mode, vecs[i].operand, vecs[i].amount,
                   vecs[i].exp_result, vecs[i].exp_carry, vecs[i].exp_zero, (i % 2) == 1, 1'b0);
        end

        // Start while busy is ignored: only one done, carrying the first result.
        @(negedge clk);
        issue(2'd0, 8'h0F, 4'd5);
        first_done = 0;
        ndone = 0;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                ndone++;
                if (first_done == 0) first_done = c;
                check("ignored result", {24'b0, result}, 32'hE0);
                check("ignored carry",  {31'b0, carry},  32'd1);
            end
            if (c == 2) begin
                operand = 8'hFF;
                mode    = 2'd3;
                amount  = 4'd2;
                start   = 1'b1;
            end
        end
        check("ignored done count", ndone, 32'd1);
        check("ignored latency", first_done, 32'd6);
        last_result = 8'hE0;

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        issue(2'd1, 8'hF3, 4'd6);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midrst busy",   {31'b0, busy},   32'd0);
        check("midrst done",   {31'b0, done},   32'd0);
        check("midrst result", {24'b0, result}, 32'd0);
        check("midrst carry",  {31'b0, carry},  32'd0);
        check("midrst zero",   {31'b0, zero},   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        check("midrst no done", ndone, 32'd0);
        last_result = 8'h00;
        run_op("post reset", 2'd0, 8'h0F, 4'd3, 8'h78, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized operations against the reference, inputs disturbed while busy.
        for (int i = 0; i < 40; i++) begin
            logic [1:0] m;
            logic [7:0] op;
            logic [3:0] n;
            m  = 2'($urandom);
            op = 8'($urandom);
            n  = 4'($urandom_range(0, 15));
            rv = ref_shift(m, op, int'(n));
            run_op($sformatf("rand%0d m%0d op%02h n%0d", i, m, op, n), m, op, n,
                   rv[7:0], rv[8], rv[7:0] == 8'h00, $urandom_range(0, 1) == 1, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle controller that sequences the ALU's single-bit shift datapath to perform shift-by-N on an 8-bit operand.
- Accepts a start request with operand, amount and mode, applies one bit step per clock, and returns result, carry and zero flags with a one-cycle done pulse.
- Sits between the instruction decoder/control unit and the ALU result mux; it replaces a wide combinational barrel shifter.

Parameters:
- WIDTH, 8, operand/result width in bits.
- AMT_W, 4, width of the shift-amount field (0..15 steps).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- operand  input  WIDTH  value to shift; captured on accepted start.
- amount  input  AMT_W  number of single-bit steps; captured on accepted start.
- mode  input  2  00=LSL, 01=LSR, 10=ASR, 11=ROL; captured on accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result and flags are valid from this cycle.
- result  output  WIDTH  shifted value; held until the next done.
- carry  output  1  last bit shifted or rotated out; 0 if amount=0.
- zero  output  1  high when result==0; updated together with result.

Behaviour:
- Reset (async, rst=1): state=IDLE. busy=0, done=0, result=0, carry=0, zero=0. Internal accumulator and counter are cleared. An in-flight operation is abandoned with no done pulse.
- States:
  - IDLE: busy=0. On a clk edge with start=1: acc<=operand, cnt<=amount, cbit<=0, mode latched, busy<=1, go to SHIFT.
  - SHIFT: if cnt!=0, one step on acc, cbit<=bit shifted out, cnt<=cnt-1.
  - SHIFT with cnt==0: result<=acc, carry<=cbit, zero<=(acc==0), done<=1, busy<=0, go to IDLE.
- Step definitions:
  - LSL: acc<={acc[W-2:0],0}, out=acc[W-1].
  - LSR: acc<={0,acc[W-1:1]}, out=acc[0].
  - ASR: acc<={acc[W-1],acc[W-1:1]}, out=acc[0].
  - ROL: acc<={acc[W-2:0],acc[W-1]}, out=acc[W-1].
- Latency: start sampled at edge 0. Steps occur at edges 1..N. done is high in the cycle after edge N+1, i.e. N+1 cycles after acceptance. amount=0 gives done after 1 cycle, result=operand, carry=0.
- No clamping: exactly amount steps are performed. Shifting LSL/LSR by >=WIDTH gives 0. ROL by 15 equals ROL by 7.
- done is asserted only while in IDLE. A start seen in the done cycle is accepted, so back-to-back operations are allowed with no gap.
- start while busy=1 is ignored and not queued.
- operand, amount and mode changes while busy=1 have no effect on the current operation.
- result, carry and zero hold their values between done pulses. A new start does not clear them until the next done.

Test Plan:
- LSL operand=8'b11001010, amount=1 -> done 2 cycles after start; result=8'b10010100, carry=1, zero=0.
- LSL 8'b00001111 amount=3 -> result=8'b01111000, carry=0, done 4 cycles after start. Then LSL 8'b10000000 amount=1 -> result=0, carry=1, zero=1.
- LSR 8'b11001010 amount=2 -> result=8'b00110010, carry=1. ASR 8'b10000000 amount=3 -> result=8'b11110000, carry=0.
- ROL 8'b11001010 amount=4 -> result=8'b10101100, carry=0. Then amount=0 with operand 8'h5A -> result=8'h5A, carry=0, done 1 cycle after start.
- Start LSL amount=5; pulse start with a different operand on cycle 2 -> the second request is ignored and a single done carries the first result. Start in the done cycle -> the second operation is accepted immediately.
- Assert rst mid-operation, asynchronously between edges -> busy, done, result, carry and zero are 0 immediately; no done pulse follows. After deassertion the next start operates normally.
